// File: rtl/shift_deserializer_nb_pkg.sv
// Shared types and sizing helpers for the shift_deserializer_nb serial receiver.
package shift_deser_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_deserializer_nb_if.sv
// Serial intake and parallel output bundle of shift_deserializer_nb.
// The ones field exists only when ONES_COUNT_EN is defined.
interface shift_deserializer_nb_if
    import shift_deser_pkg::*;
#(
    parameter int N = 8
);
    logic         sbit;
    logic         bit_valid;
    logic         bit_ready;
    logic         sof;
    logic         left_right;
    logic [N-1:0] data;
    logic         valid;
    logic         ready;
`ifdef ONES_COUNT_EN
    logic [width_of(N+1)-1:0] ones;
`endif

    modport master (
        output sbit, bit_valid, sof, left_right, ready,
        input  bit_ready, data, valid
`ifdef ONES_COUNT_EN
        , input ones
`endif
    );

    modport slave (
        input  sbit, bit_valid, sof, left_right, ready,
        output bit_ready, data, valid
`ifdef ONES_COUNT_EN
        , output ones
`endif
    );

endinterface

// File: rtl/shift_deserializer_nb_popcount.sv
// Combinational N-bit ones counter, built only when ONES_COUNT_EN is defined.
`ifdef ONES_COUNT_EN
module popcount_nb
    import shift_deser_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]              data,
    output logic [width_of(N+1)-1:0]  ones
);
    localparam int W = width_of(N + 1);

    // Sum of set bits.
    always_comb begin
        ones = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            ones = ones + {{(W-1){1'b0}}, data[i]};
        end
    end

endmodule
`endif

// File: rtl/shift_deserializer_nb.sv
// Double-buffered serial-to-parallel receiver: shift register plus output holding register.
// Optional macro ONES_COUNT_EN adds a registered population count of the output word.
module shift_deserializer_nb
    import shift_deser_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                     i_clk,
    input  logic                     i_clr,
    shift_deserializer_nb_if.slave   bus
);
    localparam int             CW   = width_of(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t          state_r, state_next_s;
    logic [CW-1:0]   cnt_r, pos_s;
    logic            dir_r, dir_eff_s, first_s;
    logic [N-1:0]    sr_r, sr_shift_s, data_r, data_next_s;
    logic            valid_r, valid_next_s;
    logic            bit_ready_s, bit_xfer_s, word_xfer_s, out_free_s;
    logic            complete_s, load_bit_s, load_sr_s;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_clr) state_r <= COLLECT;
        else       state_r <= state_next_s;
    end

    // Next state: park in FULL when a word completes against an occupied output.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            COLLECT: if (complete_s && !out_free_s) state_next_s = FULL;
                     else                           state_next_s = COLLECT;
            FULL:    if (word_xfer_s)               state_next_s = COLLECT;
                     else                           state_next_s = FULL;
            default: state_next_s = COLLECT;
        endcase
    end

    // Intake readiness is decoded from state alone.
    always_comb begin
        bit_ready_s = 1'b1;
        case (state_r)
            COLLECT: bit_ready_s = 1'b1;
            FULL:    bit_ready_s = 1'b0;
            default: bit_ready_s = 1'b1;
        endcase
    end

    assign bit_xfer_s  = bus.bit_valid && bit_ready_s;
    assign word_xfer_s = valid_r && bus.ready;
    assign out_free_s  = !valid_r || bus.ready;

    // Shift, completion and output-load decisions; sof restarts counting at this bit.
    always_comb begin
        first_s   = (cnt_r == {CW{1'b0}}) || bus.sof;
        dir_eff_s = first_s ? bus.left_right : dir_r;
        pos_s     = bus.sof ? {CW{1'b0}} : cnt_r;
        if (dir_eff_s == DIR_RIGHT) sr_shift_s = {bus.sbit, sr_r[N-1:1]};
        else                        sr_shift_s = {sr_r[N-2:0], bus.sbit};
        complete_s = bit_xfer_s && (pos_s == LAST);
        load_bit_s = complete_s && out_free_s;
        load_sr_s  = (state_r == FULL) && word_xfer_s;
        if (load_bit_s)     data_next_s = sr_shift_s;
        else if (load_sr_s) data_next_s = sr_r;
        else                data_next_s = data_r;
        if (load_bit_s || load_sr_s) valid_next_s = 1'b1;
        else if (word_xfer_s)        valid_next_s = 1'b0;
        else                         valid_next_s = valid_r;
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            sr_r    <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
            dir_r   <= DIR_LEFT;
            data_r  <= {N{1'b0}};
            valid_r <= 1'b0;
        end else begin
            if (bit_xfer_s) begin
                sr_r  <= sr_shift_s;
                cnt_r <= complete_s ? {CW{1'b0}} : (pos_s + CW'(1));
                if (first_s) dir_r <= bus.left_right;
            end
            data_r  <= data_next_s;
            valid_r <= valid_next_s;
        end
    end

    assign bus.bit_ready = bit_ready_s;
    assign bus.data      = data_r;
    assign bus.valid     = valid_r;

`ifdef ONES_COUNT_EN
    localparam int OW = width_of(N + 1);
    logic [OW-1:0] ones_next_s, ones_r;

    popcount_nb #(.N(N)) u_popcount (
        .data (data_next_s),
        .ones (ones_next_s)
    );

    // Count registered alongside the word it describes.
    always_ff @(posedge i_clk) begin
        if (i_clr) ones_r <= {OW{1'b0}};
        else       ones_r <= ones_next_s;
    end

    assign bus.ones = ones_r;
`endif

endmodule

// File: tb/tb_shift_deserializer_nb.sv
// Scoreboard bench for shift_deserializer_nb: directed scenarios followed by random traffic.
module tb_shift_deserializer_nb;
    localparam int N = 8;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    shift_deserializer_nb_if #(.N(N)) bus ();

    shift_deserializer_nb #(.N(N)) dut (
        .i_clk (clk),
        .i_clr (clr),
        .bus   (bus)
    );

    int           vectors     = 0;
    int           miscompares = 0;
    int           words_out   = 0;
    logic [N-1:0] exp_q[$];
    bit           m_bits[$];
    logic         m_dir;
    bit           rand_mode   = 1'b0;
    bit           watch_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_bits.delete();
        m_dir = 1'b0;
    endtask

    // Reference: collect bits of a word; first bit lands at MSB (left) or LSB (right).
    task automatic model_accept(input bit b, input bit sof, input bit lr);
        logic [N-1:0] w;
        if (sof || m_bits.size() == 0) begin
            m_bits.delete();
            m_dir = lr;
        end
        m_bits.push_back(b);
        if (m_bits.size() == N) begin
            w = '0;
            for (int k = 0; k < N; k++) begin
                if (m_dir == 1'b0) w[N-1-k] = m_bits[k];
                else               w[k]     = m_bits[k];
            end
            exp_q.push_back(w);
            m_bits.delete();
        end
    endtask

    task automatic send_bit(input bit b, input bit sof, input bit lr);
        bit accepted = 1'b0;
        bit acc_now;
        bus.sbit       = b;
        bus.sof        = sof;
        bus.left_right = lr;
        bus.bit_valid  = 1'b1;
        for (int t = 0; t < 64 && !accepted; t++) begin
            @(negedge clk);
            acc_now = bus.bit_ready;
            @(posedge clk);
            if (acc_now) begin
                accepted = 1'b1;
                model_accept(b, sof, lr);
            end
            #1;
            if (rand_mode) bus.ready = 1'($urandom_range(0, 1));
        end
        bus.bit_valid = 1'b0;
        bus.sof       = 1'b0;
        if (!accepted) begin
            vectors++;
            miscompares++;
            $display("FAIL bit_accept_timeout: got no acceptance expected acceptance within 64 cycles");
        end
    endtask

    // Transmit seq[N-1] first.
    task automatic send_seq(input logic [N-1:0] seq, input bit lr);
        for (int k = N - 1; k >= 0; k--) send_bit(seq[k], 1'b0, lr);
    endtask

    task automatic idle(input int n);
        bus.bit_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_mode) bus.ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
        @(negedge clk);
        check("clr_valid", bus.valid, 0);
        check("clr_data", bus.data, 0);
        check("clr_bit_ready", bus.bit_ready, 1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop expected word on each word transfer; check holding stability.
    logic [N-1:0] mon_e;
    logic [N-1:0] p_data;
    bit           p_hold = 1'b0;
    always @(negedge clk) begin
        if (!clr && bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_word: got %0h expected no word", bus.data);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", bus.data, mon_e);
`ifdef ONES_COUNT_EN
                check("word_ones", bus.ones, $countones(mon_e));
`endif
                words_out++;
            end
        end
        if (!clr && p_hold) check("hold_stable", bus.data, p_data);
        p_hold = !clr && bus.valid && !bus.ready;
        p_data = bus.data;
        if (watch_ready) check("no_stall", bus.bit_ready, 1);
    end

    int w0;
    initial begin
        bus.sbit = 1'b0; bus.bit_valid = 1'b0; bus.sof = 1'b0;
        bus.left_right = 1'b0; bus.ready = 1'b0;
        model_reset();
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        check("rst_valid", bus.valid, 0);
        check("rst_data", bus.data, 0);
        check("rst_bit_ready", bus.bit_ready, 1);
`ifdef ONES_COUNT_EN
        check("rst_ones", bus.ones, 0);
`endif
        @(posedge clk);
        #1;

        // Left assembly of 1,0,1,1,0,0,0,1.
        bus.ready = 1'b1;
        send_seq(8'b1011_0001, 1'b0);
        @(negedge clk);
        check("left_valid", bus.valid, 1);
        check("left_data", bus.data, 8'hB1);
`ifdef ONES_COUNT_EN
        check("left_ones", bus.ones, 4);
`endif
        @(posedge clk);
        #1;

        // Same bits, right assembly.
        send_seq(8'b1011_0001, 1'b1);
        @(negedge clk);
        check("right_data", bus.data, 8'h8D);
        @(posedge clk);
        #1;

        // Both buffers full, then drain.
        bus.ready = 1'b0;
        send_seq(8'hA5, 1'b0);
        send_seq(8'h3C, 1'b0);
        @(negedge clk);
        check("full_bit_ready", bus.bit_ready, 0);
        check("full_data", bus.data, 8'hA5);
        @(posedge clk);
        #1;
        bus.ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("drain_data", bus.data, 8'h3C);
        check("drain_bit_ready", bus.bit_ready, 1);
        @(posedge clk);
        #1;

        // Three stray bits, then sof-started word.
        idle(2);
        w0 = words_out;
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        for (int k = N - 2; k >= 0; k--) send_bit(bit'(8'h5A >> k), 1'b0, 1'b0);
        idle(3);
        check("sof_word_count", words_out - w0, 1);
        check("sof_queue_empty", exp_q.size(), 0);

        // Completing bit coinciding with a word transfer.
        watch_ready = 1'b1;
        bus.ready = 1'b0;
        send_seq(8'h69, 1'b0);
        for (int k = N - 1; k >= 1; k--) send_bit(bit'(8'hF0 >> k), 1'b0, 1'b0);
        bus.ready = 1'b1;
        send_bit(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("overlap_data", bus.data, 8'hF0);
        check("overlap_valid", bus.valid, 1);
        @(posedge clk);
        #1;
        idle(2);
        watch_ready = 1'b0;

        // Reset while FULL, then reset mid-word.
        bus.ready = 1'b0;
        send_seq(8'h11, 1'b0);
        send_seq(8'h22, 1'b0);
        @(negedge clk);
        check("pre_clr_full", bus.bit_ready, 0);
        @(posedge clk);
        #1;
        pulse_clr();
        bus.ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        pulse_clr();
        w0 = words_out;
        send_seq(8'hC3, 1'b0);
        idle(3);
        check("post_clr_words", words_out - w0, 1);

        // Random traffic.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idle(1);
            send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                     1'($urandom_range(0, 1)));
        end
        rand_mode = 1'b0;
        bus.ready = 1'b1;
        idle(6);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
